// File: rtl/echo_initiator.sv
// rtl/echo_initiator.sv - UART echo initiator for link bring-up and loopback self-test
//
// Sends NUM_WORDS test words as 8N1 frames (LSB first) on txd. After each
// frame it waits for the echo on rxd, compares it with the word it sent, and
// accumulates an error count. The error count covers mismatches, timeouts and
// framing errors. A pass/fail verdict is given at the end of the run.
//
// Build option (macro ECHO_PATTERN_LFSR_EN):
//   defined   - payload comes from an 8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1,
//               seeded 0xA5 at each accepted start and stepped once per word
//   undefined - payload is an incrementing counter starting at 0x00
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   start      one-cycle pulse that begins a run (ignored while busy)
//   rxd        serial data from the responder, idle high, asynchronous to clk
//   txd        serial data to the responder, idle high
//   busy       run in progress
//   done       run complete; held until the next accepted start or reset
//   pass       valid while done=1; 1 when err_count==0
//   err_count  saturating error count for the current/last run
//   last_sent  most recently transmitted word
//   last_recv  most recently received word

module echo_initiator #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int NUM_WORDS      = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rxd,
  output logic       txd,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] last_sent,
  output logic [7:0] last_recv
);

  localparam int BIT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       IDX_LAST  = 8'(NUM_WORDS - 1);

`ifdef ECHO_PATTERN_LFSR_EN
  localparam logic [7:0] FIRST_WORD = 8'hA5;

  // Fibonacci form: taps x^8, x^6, x^5, x^4 feed back into bit 0.
  function automatic logic [7:0] next_word(input logic [7:0] w);
    return {w[6:0], w[7] ^ w[5] ^ w[4] ^ w[3]};
  endfunction
`else
  localparam logic [7:0] FIRST_WORD = 8'h00;

  function automatic logic [7:0] next_word(input logic [7:0] w);
    return w + 8'd1;
  endfunction
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // --------------------------------------------------------------------
  // rxd synchroniser; rxd_prev gives the falling-edge reference
  // --------------------------------------------------------------------
  logic rxd_meta, rxd_sync, rxd_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // --------------------------------------------------------------------
  // Receive deserialiser (runs continuously; the control FSM decides
  // whether a completed byte is of interest)
  // --------------------------------------------------------------------
  typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state, rx_state_nx;
  logic [BIT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic             rx_ferr;
  logic             rx_tick_half;
  logic             rx_tick_bit;

  assign rx_tick_half = (rx_cnt == HALF_LAST);
  assign rx_tick_bit  = (rx_cnt == BIT_LAST);

  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      RX_HUNT:  if (rxd_prev && !rxd_sync) rx_state_nx = RX_START;
      // A start bit that is high again at its midpoint was a glitch.
      RX_START: if (rx_tick_half) rx_state_nx = rxd_sync ? RX_HUNT : RX_DATA;
      RX_DATA:  if (rx_tick_bit && rx_bit == 3'd7) rx_state_nx = RX_STOP;
      RX_STOP:  if (rx_tick_bit) rx_state_nx = RX_HUNT;
      default:  rx_state_nx = RX_HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_HUNT;
    else     rx_state <= rx_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // The bit timer restarts on every state change and at each bit
      // boundary, so sampling after the half-bit start check lands mid-bit.
      if (rx_state_nx != rx_state || rx_tick_bit) rx_cnt <= '0;
      else                                        rx_cnt <= rx_cnt + 1'b1;
      case (rx_state)
        RX_DATA: begin
          if (rx_tick_bit) begin
            rx_shift <= {rxd_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
          end
        end
        RX_STOP: begin
          if (rx_tick_bit) begin
            rx_valid <= 1'b1;
            rx_ferr  <= !rxd_sync;
            rx_byte  <= rx_shift;
          end
        end
        default: rx_bit <= 3'd0;
      endcase
    end
  end

  // --------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------
  typedef enum logic [2:0] {IDLE, SEND, WAIT_ECHO, CHECK, DONE} state_t;

  state_t           state, state_nx;
  logic [BIT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;     // frame bit on the line: 0 = start .. 9 = stop
  logic [8:0]       tx_shift;   // remaining data bits plus stop bit
  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       idx;
  logic [7:0]       payload;
  logic             got_ok;     // echo arrived without a framing error
  logic             tx_tick;
  logic             tx_end;
  logic             timeout;
  logic             load_first;
  logic             load_next;
  logic [7:0]       tx_word;

  assign tx_tick = (tx_cnt == BIT_LAST);
  assign tx_end  = tx_tick && (tx_bit == 4'd9);
  assign timeout = (to_cnt == TO_LAST);
  assign tx_word = load_first ? FIRST_WORD : next_word(payload);

  always_comb begin
    state_nx   = state;
    load_first = 1'b0;
    load_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = SEND;
          load_first = 1'b1;
        end
      end
      SEND:      if (tx_end) state_nx = WAIT_ECHO;
      // A frame completing on the timeout cycle still counts as received.
      WAIT_ECHO: if (rx_valid || timeout) state_nx = CHECK;
      CHECK: begin
        if (idx == IDX_LAST) begin
          state_nx = DONE;
        end else begin
          state_nx  = SEND;
          load_next = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd       <= 1'b1;
      tx_cnt    <= '0;
      tx_bit    <= 4'd0;
      tx_shift  <= '1;
      to_cnt    <= '0;
      idx       <= 8'd0;
      payload   <= 8'h00;
      got_ok    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 8'd0;
      last_sent <= 8'h00;
      last_recv <= 8'h00;
    end else begin
      // Transmit serialiser: the start bit goes out on the load edge.
      if (load_first || load_next) begin
        txd       <= 1'b0;
        tx_shift  <= {1'b1, tx_word};
        tx_cnt    <= '0;
        tx_bit    <= 4'd0;
        payload   <= tx_word;
        last_sent <= tx_word;
      end else if (state == SEND) begin
        if (tx_tick) begin
          tx_cnt <= '0;
          if (!tx_end) begin
            txd      <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_bit   <= tx_bit + 4'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end

      if (load_first) begin
        idx       <= 8'd0;
        err_count <= 8'd0;
        done      <= 1'b0;
        pass      <= 1'b0;
        busy      <= 1'b1;
      end
      if (load_next) idx <= idx + 8'd1;

      if (state == SEND && tx_end)               to_cnt <= '0;
      else if (state == WAIT_ECHO && !timeout)   to_cnt <= to_cnt + 1'b1;

      if (state == WAIT_ECHO) begin
        if (rx_valid) begin
          last_recv <= rx_byte;
          got_ok    <= !rx_ferr;
          if (rx_ferr) err_count <= sat_inc(err_count);
        end else if (timeout) begin
          got_ok    <= 1'b0;
          err_count <= sat_inc(err_count);
        end
      end

      if (state == CHECK && got_ok && last_recv != last_sent)
        err_count <= sat_inc(err_count);

      if (state == DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_echo_initiator.sv
// tb/tb_echo_initiator.sv - self-checking bench for echo_initiator with a behavioural echo responder

`timescale 1ns/1ps

module tb_echo_initiator;

  localparam int CPB = 4;
  localparam int TO  = 100;
`ifdef ECHO_PATTERN_LFSR_EN
  localparam int NW  = 3;
`else
  localparam int NW  = 4;
`endif
  localparam int BUDGET = 5000;

  localparam int M_ECHO    = 0;
  localparam int M_CORRUPT = 1;
  localparam int M_SILENT  = 2;
  localparam int M_BADSTOP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rxd;
  logic       txd;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [7:0] last_sent;
  logic [7:0] last_recv;

  int         n_cmp = 0;
  int         n_bad = 0;

  int         resp_mode [NW];
  logic [7:0] resp_add  [NW];
  int         resp_delay[NW];
  int         resp_idx;
  logic [7:0] sent_q[$];
  logic [7:0] exp_recv;

  echo_initiator #(
    .CLKS_PER_BIT  (CPB),
    .NUM_WORDS     (NW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rxd      (rxd),
    .txd      (txd),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .last_sent(last_sent),
    .last_recv(last_recv)
  );

  always #5 clk = ~clk;

  // Word k of a run, from the pattern definition.
  function automatic logic [7:0] model_word(input int k);
    logic [7:0] w;
`ifdef ECHO_PATTERN_LFSR_EN
    w = 8'hA5;
    for (int i = 0; i < k; i++) w = {w[6:0], ^(w & 8'hB8)};
`else
    w = 8'(k);
`endif
    return w;
  endfunction

  // ------------------------------------------------------------------
  // Echo responder: decodes each txd frame, then answers on rxd once the
  // stop bit has ended, as configured per word index.
  // ------------------------------------------------------------------
  task automatic resp_wait(input int n, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) begin
        aborted = 1'b1;
        return;
      end
    end
  endtask

  task automatic resp_frame();
    logic [7:0] b;
    logic [7:0] r;
    bit         ab;
    int         k;
    int         mode;
    @(negedge clk);
    while (rst || txd !== 1'b0) @(negedge clk);
    resp_wait(CPB / 2, ab);
    if (ab) return;
    for (int i = 0; i < 8; i++) begin
      resp_wait(CPB, ab);
      if (ab) return;
      b[i] = txd;
    end
    resp_wait(CPB, ab);
    if (ab) return;
    sent_q.push_back(b);
    k = resp_idx;
    resp_idx++;
    mode = (k < NW) ? resp_mode[k] : M_ECHO;
    resp_wait(CPB / 2 + ((k < NW) ? resp_delay[k] : 0), ab);
    if (ab) return;
    if (mode == M_SILENT) return;
    r = (mode == M_CORRUPT) ? b + resp_add[k] : b;
    rxd = 1'b0;
    resp_wait(CPB, ab);
    if (ab) begin
      rxd = 1'b1;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      rxd = r[i];
      resp_wait(CPB, ab);
      if (ab) begin
        rxd = 1'b1;
        return;
      end
    end
    rxd = (mode == M_BADSTOP) ? 1'b0 : 1'b1;
    resp_wait(CPB, ab);
    rxd = 1'b1;
  endtask

  initial begin
    rxd = 1'b1;
    forever resp_frame();
  end

  // ------------------------------------------------------------------
  // Run control
  // ------------------------------------------------------------------
  task automatic set_modes(input int mode);
    for (int i = 0; i < NW; i++) begin
      resp_mode[i]  = mode;
      resp_add[i]   = 8'd1;
      resp_delay[i] = 0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 1;
    while (done !== 1'b1 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic run(output int cyc, output bit ok);
    sent_q.delete();
    resp_idx = 0;
    pulse_start();
    wait_done(cyc, ok);
    repeat (4) @(negedge clk);
  endtask

  // ------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------
  task automatic test_reset();
    #1;
    n_cmp++; if (txd !== 1'b1)       begin n_bad++; $display("FAIL reset_txd: got %b expected 1", txd); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (pass !== 1'b0)      begin n_bad++; $display("FAIL reset_pass: got %b expected 0", pass); end
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL reset_err: got %0d expected 0", err_count); end
    n_cmp++; if (last_sent !== 8'd0) begin n_bad++; $display("FAIL reset_last_sent: got %h expected 00", last_sent); end
    n_cmp++; if (last_recv !== 8'd0) begin n_bad++; $display("FAIL reset_last_recv: got %h expected 00", last_recv); end
  endtask

  task automatic test_loopback();
    int cyc;
    bit ok;
    set_modes(M_ECHO);
    run(cyc, ok);
    exp_recv = model_word(NW - 1);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL loop_done: got no done within %0d cycles", BUDGET); end
    n_cmp++; if (sent_q.size() != NW) begin n_bad++; $display("FAIL loop_count: got %0d words expected %0d", sent_q.size(), NW); end
    for (int k = 0; k < NW && k < sent_q.size(); k++) begin
      n_cmp++;
      if (sent_q[k] !== model_word(k)) begin n_bad++; $display("FAIL loop_word%0d: got %h expected %h", k, sent_q[k], model_word(k)); end
    end
    n_cmp++; if (pass !== 1'b1)       begin n_bad++; $display("FAIL loop_pass: got %b expected 1", pass); end
    n_cmp++; if (err_count !== 8'd0)  begin n_bad++; $display("FAIL loop_err: got %0d expected 0", err_count); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL loop_busy: got %b expected 0", busy); end
    n_cmp++; if (last_recv !== exp_recv) begin n_bad++; $display("FAIL loop_last_recv: got %h expected %h", last_recv, exp_recv); end
    n_cmp++; if (last_sent !== model_word(NW - 1)) begin n_bad++; $display("FAIL loop_last_sent: got %h expected %h", last_sent, model_word(NW - 1)); end
  endtask

  task automatic test_corrupt();
    int cyc;
    bit ok;
    set_modes(M_CORRUPT);
    run(cyc, ok);
    exp_recv = model_word(NW - 1) + 8'd1;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL plus1_done: got no done within %0d cycles", BUDGET); end
    n_cmp++; if (err_count !== 8'(NW)) begin n_bad++; $display("FAIL plus1_err: got %0d expected %0d", err_count, NW); end
    n_cmp++; if (pass !== 1'b0)        begin n_bad++; $display("FAIL plus1_pass: got %b expected 0", pass); end
    n_cmp++; if (last_sent !== model_word(NW - 1)) begin n_bad++; $display("FAIL plus1_last_sent: got %h expected %h", last_sent, model_word(NW - 1)); end
    n_cmp++; if (last_recv !== exp_recv) begin n_bad++; $display("FAIL plus1_last_recv: got %h expected %h", last_recv, exp_recv); end
  endtask

  task automatic test_timeout();
    int cyc;
    bit ok;
    int exp_cyc;
    set_modes(M_SILENT);
    run(cyc, ok);
    exp_cyc = NW * (10 * CPB + TO);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_done: got no done within %0d cycles", BUDGET); end
    n_cmp++; if (err_count !== 8'(NW)) begin n_bad++; $display("FAIL tmo_err: got %0d expected %0d", err_count, NW); end
    n_cmp++; if (pass !== 1'b0)        begin n_bad++; $display("FAIL tmo_pass: got %b expected 0", pass); end
    n_cmp++; if (last_recv !== exp_recv) begin n_bad++; $display("FAIL tmo_last_recv: got %h expected %h", last_recv, exp_recv); end
    n_cmp++;
    if (cyc < exp_cyc || cyc > exp_cyc + 4 * NW) begin
      n_bad++;
      $display("FAIL tmo_runtime: got %0d cycles expected %0d..%0d", cyc, exp_cyc, exp_cyc + 4 * NW);
    end
  endtask

  task automatic test_frame_error();
    int cyc;
    bit ok;
    set_modes(M_ECHO);
    resp_mode[1] = M_BADSTOP;
    run(cyc, ok);
    exp_recv = model_word(NW - 1);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ferr_done: got no done within %0d cycles", BUDGET); end
    n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL ferr_err: got %0d expected 1", err_count); end
    n_cmp++; if (pass !== 1'b0)      begin n_bad++; $display("FAIL ferr_pass: got %b expected 0", pass); end
    n_cmp++; if (last_recv !== exp_recv) begin n_bad++; $display("FAIL ferr_last_recv: got %h expected %h", last_recv, exp_recv); end
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    bit ok;
    int w;
    set_modes(M_ECHO);
    sent_q.delete();
    resp_idx = 0;
    pulse_start();
    w = 0;
    while (sent_q.size() < 2 && w < BUDGET) begin @(negedge clk); w++; end
    while (txd !== 1'b0 && w < BUDGET) begin @(negedge clk); w++; end
    n_cmp++; if (w >= BUDGET) begin n_bad++; $display("FAIL rstmid_reach_word2: got no word 2 start within %0d cycles", BUDGET); end
    repeat (2 * CPB + 1) @(negedge clk);
    n_cmp++; if (last_sent !== model_word(2)) begin n_bad++; $display("FAIL rstmid_pre_last_sent: got %h expected %h", last_sent, model_word(2)); end
    rst = 1'b1;
    #1;
    n_cmp++; if (txd !== 1'b1)       begin n_bad++; $display("FAIL rstmid_txd: got %b expected 1", txd); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL rstmid_done: got %b expected 0", done); end
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL rstmid_err: got %0d expected 0", err_count); end
    n_cmp++; if (last_sent !== 8'd0) begin n_bad++; $display("FAIL rstmid_last_sent: got %h expected 00", last_sent); end
    n_cmp++; if (last_recv !== 8'd0) begin n_bad++; $display("FAIL rstmid_last_recv: got %h expected 00", last_recv); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run(cyc, ok);
    exp_recv = model_word(NW - 1);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_rerun_done: got no done within %0d cycles", BUDGET); end
    n_cmp++; if (pass !== 1'b1)      begin n_bad++; $display("FAIL rstmid_rerun_pass: got %b expected 1", pass); end
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL rstmid_rerun_err: got %0d expected 0", err_count); end
    n_cmp++; if (sent_q.size() != NW) begin n_bad++; $display("FAIL rstmid_rerun_count: got %0d words expected %0d", sent_q.size(), NW); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    set_modes(M_ECHO);
    sent_q.delete();
    resp_idx = 0;
    pulse_start();
    repeat (20) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    pulse_start();
    wait_done(cyc, ok);
    repeat (4) @(negedge clk);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_done: got no done within %0d cycles", BUDGET); end
    n_cmp++; if (sent_q.size() != NW) begin n_bad++; $display("FAIL b2b_count: got %0d words expected %0d", sent_q.size(), NW); end
    for (int k = 0; k < NW && k < sent_q.size(); k++) begin
      n_cmp++;
      if (sent_q[k] !== model_word(k)) begin n_bad++; $display("FAIL b2b_word%0d: got %h expected %h", k, sent_q[k], model_word(k)); end
    end
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL b2b_pass: got %b expected 1", pass); end
    run(cyc, ok);
    exp_recv = model_word(NW - 1);
    n_cmp++; if (!ok || pass !== 1'b1) begin n_bad++; $display("FAIL b2b_second_run: got done=%b pass=%b expected done=1 pass=1", done, pass); end
    n_cmp++; if (sent_q.size() != NW) begin n_bad++; $display("FAIL b2b_second_count: got %0d words expected %0d", sent_q.size(), NW); end
  endtask

  task automatic test_random();
    int cyc;
    bit ok;
    int r;
    int exp_err;
    logic [7:0] w;
    for (int it = 0; it < 6; it++) begin
      exp_err = 0;
      for (int k = 0; k < NW; k++) begin
        r = $urandom_range(0, 5);
        resp_mode[k]  = (r <= 2) ? M_ECHO : (r == 3) ? M_CORRUPT : (r == 4) ? M_SILENT : M_BADSTOP;
        resp_add[k]   = 8'($urandom_range(1, 255));
        resp_delay[k] = $urandom_range(0, 20);
        w = model_word(k);
        if (resp_mode[k] != M_ECHO)   exp_err++;
        if (resp_mode[k] != M_SILENT) exp_recv = (resp_mode[k] == M_CORRUPT) ? w + resp_add[k] : w;
      end
      repeat ($urandom_range(0, 7)) @(negedge clk);
      run(cyc, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd%0d_done: got no done within %0d cycles", it, BUDGET); end
      n_cmp++; if (err_count !== 8'(exp_err)) begin n_bad++; $display("FAIL rnd%0d_err: got %0d expected %0d", it, err_count, exp_err); end
      n_cmp++; if (pass !== (exp_err == 0)) begin n_bad++; $display("FAIL rnd%0d_pass: got %b expected %b", it, pass, exp_err == 0); end
      n_cmp++; if (last_recv !== exp_recv) begin n_bad++; $display("FAIL rnd%0d_last_recv: got %h expected %h", it, last_recv, exp_recv); end
      n_cmp++; if (last_sent !== model_word(NW - 1)) begin n_bad++; $display("FAIL rnd%0d_last_sent: got %h expected %h", it, last_sent, model_word(NW - 1)); end
      n_cmp++; if (sent_q.size() != NW) begin n_bad++; $display("FAIL rnd%0d_count: got %0d words expected %0d", it, sent_q.size(), NW); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    exp_recv = 8'h00;
    resp_idx = 0;
    set_modes(M_ECHO);
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_loopback();
    test_corrupt();
    test_timeout();
    test_frame_error();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
